// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter for the Tomasulo core.
// Each producer channel feeds a small circular FIFO; channels are drained
// round-robin onto one registered broadcast bus (tag = RoB id, data = result).
module cdb_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 5,
  parameter int FIFO_DEPTH = 4,
  localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      rollback_in,
  input  logic [NUM_SRC-1:0]        src_valid_in,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag_in,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_in,
  output logic [NUM_SRC-1:0]        src_full_out,
  output logic [NUM_SRC-1:0]        overflow_out,
  output logic                      cdb_valid_out,
  output logic [TAG_W-1:0]          cdb_tag_out,
  output logic [DATA_W-1:0]         cdb_data_out,
  output logic [SRC_W-1:0]          cdb_src_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  logic [TAG_W-1:0]   tag_mem  [NUM_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0]  data_mem [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr   [NUM_SRC];
  logic [PTR_W-1:0]   rd_ptr   [NUM_SRC];
  logic [CNT_W-1:0]   count    [NUM_SRC];
  logic [SRC_W-1:0]   last_grant;

  logic               active;
  logic               grant_vld_p0;
  logic [SRC_W-1:0]   grant_idx_p0;
  logic [TAG_W-1:0]   grant_tag_p0;
  logic [DATA_W-1:0]  grant_data_p0;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] drop;

  logic               cdb_vld_p1;
  logic [TAG_W-1:0]   cdb_tag_p1;
  logic [DATA_W-1:0]  cdb_data_p1;
  logic [SRC_W-1:0]   cdb_src_p1;

  // A rollback or a global stall suppresses every push and grant this cycle.
  assign active = rdy_in && !rollback_in;

  // Round-robin scan: first non-empty channel after the last granted one.
  always_comb begin
    grant_vld_p0 = 1'b0;
    grant_idx_p0 = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      if (!grant_vld_p0 && (count[(int'(last_grant) + k) % NUM_SRC] != '0)) begin
        grant_vld_p0 = 1'b1;
        grant_idx_p0 = SRC_W'((int'(last_grant) + k) % NUM_SRC);
      end
    end
  end

  // Head of the granted channel's FIFO.
  assign grant_tag_p0  = tag_mem[grant_idx_p0][rd_ptr[grant_idx_p0]];
  assign grant_data_p0 = data_mem[grant_idx_p0][rd_ptr[grant_idx_p0]];

  // Per-channel push/pop/drop; a full FIFO still accepts if it pops this cycle.
  always_comb begin
    push         = '0;
    pop          = '0;
    drop         = '0;
    src_full_out = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_full_out[i] = (count[i] == FULL_CNT);
      pop[i]  = active && grant_vld_p0 && (int'(grant_idx_p0) == i);
      push[i] = active && src_valid_in[i] && ((count[i] != FULL_CNT) || pop[i]);
      drop[i] = active && src_valid_in[i] && (count[i] == FULL_CNT) && !pop[i];
    end
  end

  // FIFO pointers, occupancy and sticky overflow flags.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      overflow_out <= '0;
    end else if (rdy_in) begin
      if (rollback_in) begin
        for (int i = 0; i < NUM_SRC; i++) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          count[i]  <= '0;
        end
      end else begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
          if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
          if (push[i] && !pop[i])
            count[i] <= count[i] + 1'b1;
          else if (!push[i] && pop[i])
            count[i] <= count[i] - 1'b1;
          if (drop[i]) overflow_out[i] <= 1'b1;
        end
      end
    end
  end

  // FIFO storage; payload needs no reset since occupancy guards every read.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        tag_mem[i][wr_ptr[i]]  <= src_tag_in[i*TAG_W +: TAG_W];
        data_mem[i][wr_ptr[i]] <= src_data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---- p0 -> p1: granted head is registered onto the broadcast bus ----
  // Broadcast register and round-robin pointer; payload holds when idle.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_grant  <= SRC_W'(NUM_SRC - 1);
      cdb_vld_p1  <= 1'b0;
      cdb_tag_p1  <= '0;
      cdb_data_p1 <= '0;
      cdb_src_p1  <= '0;
    end else if (rdy_in) begin
      if (rollback_in) begin
        cdb_vld_p1 <= 1'b0;
      end else if (grant_vld_p0) begin
        last_grant  <= grant_idx_p0;
        cdb_vld_p1  <= 1'b1;
        cdb_tag_p1  <= grant_tag_p0;
        cdb_data_p1 <= grant_data_p0;
        cdb_src_p1  <= grant_idx_p0;
      end else begin
        cdb_vld_p1 <= 1'b0;
      end
    end
  end

  assign cdb_valid_out = cdb_vld_p1;
  assign cdb_tag_out   = cdb_tag_p1;
  assign cdb_data_out  = cdb_data_p1;
  assign cdb_src_out   = cdb_src_p1;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter (NUM_SRC=2, FIFO_DEPTH=4): vector table plus
// hand-written sequences, with a per-channel scoreboard on the broadcast bus.
module tb_cdb_arbiter;

  localparam int NS = 2;
  localparam int DW = 32;
  localparam int TW = 5;
  localparam int FD = 4;

  logic              clk_in = 1'b0;
  logic              rst_in = 1'b0;
  logic              rdy_in = 1'b0;
  logic              rollback_in = 1'b0;
  logic [NS-1:0]     src_valid_in = '0;
  logic [NS*TW-1:0]  src_tag_in = '0;
  logic [NS*DW-1:0]  src_data_in = '0;
  logic [NS-1:0]     src_full_out;
  logic [NS-1:0]     overflow_out;
  logic              cdb_valid_out;
  logic [TW-1:0]     cdb_tag_out;
  logic [DW-1:0]     cdb_data_out;
  logic [0:0]        cdb_src_out;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(
    .NUM_SRC(NS), .DATA_W(DW), .TAG_W(TW), .FIFO_DEPTH(FD)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .rollback_in(rollback_in),
    .src_valid_in(src_valid_in),
    .src_tag_in(src_tag_in),
    .src_data_in(src_data_in),
    .src_full_out(src_full_out),
    .overflow_out(overflow_out),
    .cdb_valid_out(cdb_valid_out),
    .cdb_tag_out(cdb_tag_out),
    .cdb_data_out(cdb_data_out),
    .cdb_src_out(cdb_src_out)
  );

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct packed {
    logic          do_rst;
    logic [1:0]    vld;
    logic [TW-1:0] t0;
    logic [TW-1:0] t1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          e_vld;
    logic [TW-1:0] e_tag;
    logic [DW-1:0] e_data;
    logic          e_src;
  } vec_t;

  ent_t q0[$];
  ent_t q1[$];
  ent_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  logic last_rdy = 1'b0;
  vec_t tbl [15];
  logic [1:0] acc;

  function automatic logic [DW-1:0] dat(input int ch, input int tag);
    return 32'hC0DE_0000 + 32'(ch * 256 + tag);
  endfunction

  function automatic vec_t mk(input logic r, input logic [1:0] v, input int t0, input int t1,
                              input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                              input logic ev, input int et, input logic [DW-1:0] ed, input logic es);
    vec_t x;
    x.do_rst = r;  x.vld = v;
    x.t0 = TW'(t0); x.t1 = TW'(t1);
    x.d0 = d0;      x.d1 = d1;
    x.e_vld = ev;   x.e_tag = TW'(et); x.e_data = ed; x.e_src = es;
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Drive one cycle of inputs; entries the bench expects to be accepted go to the scoreboard.
  task automatic drive(input logic rdy, input logic rb, input logic [1:0] vld,
                       input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                       input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [1:0] ac);
    ent_t e;
    rdy_in = rdy;
    rollback_in = rb;
    src_valid_in = vld;
    src_tag_in = {t1, t0};
    src_data_in = {d1, d0};
    if (ac[0]) begin e.tag = t0; e.data = d0; q0.push_back(e); end
    if (ac[1]) begin e.tag = t1; e.data = d1; q1.push_back(e); end
    tick();
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 2'b00, '0, '0, '0, '0, 2'b00);
  endtask

  task automatic do_reset();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    rollback_in = 1'b0;
    src_valid_in = '0;
    src_tag_in = '0;
    src_data_in = '0;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b1;
  endtask

  task automatic check_drained(input string name);
    check(name, 64'(q0.size() + q1.size()), 64'd0);
  endtask

  // Only edges taken with rdy_in high produce a new broadcast.
  always @(posedge clk_in) last_rdy <= rdy_in;

  // Scoreboard: every broadcast must be the oldest outstanding entry of its channel.
  always @(negedge clk_in) begin
    if (rst_in && last_rdy && cdb_valid_out) begin
      n_chk++;
      if (cdb_src_out == 1'b0 && q0.size() > 0) begin
        mon_e = q0.pop_front();
        if (mon_e.tag !== cdb_tag_out || mon_e.data !== cdb_data_out) begin
          n_fail++;
          $display("FAIL sb_ch0: got tag %0h data %0h, expected tag %0h data %0h",
                   cdb_tag_out, cdb_data_out, mon_e.tag, mon_e.data);
        end
      end else if (cdb_src_out == 1'b1 && q1.size() > 0) begin
        mon_e = q1.pop_front();
        if (mon_e.tag !== cdb_tag_out || mon_e.data !== cdb_data_out) begin
          n_fail++;
          $display("FAIL sb_ch1: got tag %0h data %0h, expected tag %0h data %0h",
                   cdb_tag_out, cdb_data_out, mon_e.tag, mon_e.data);
        end
      end else begin
        n_fail++;
        $display("FAIL sb_unexpected: got broadcast src %0d tag %0h, expected none",
                 cdb_src_out, cdb_tag_out);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single push latency and bus hold, then round-robin interleave.
    tbl[0]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 2'b01, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 2'b00, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0);
    tbl[4]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0);
    tbl[5]  = mk(1, 2'b11, 1, 11, dat(0, 1), dat(1, 11), 0, 0, 0, 0);
    tbl[6]  = mk(0, 2'b11, 2, 12, dat(0, 2), dat(1, 12), 1, 1, dat(0, 1), 0);
    tbl[7]  = mk(0, 2'b11, 3, 13, dat(0, 3), dat(1, 13), 1, 11, dat(1, 11), 1);
    tbl[8]  = mk(0, 2'b11, 4, 14, dat(0, 4), dat(1, 14), 1, 2, dat(0, 2), 0);
    tbl[9]  = mk(0, 2'b00, 0, 0, 0, 0, 1, 12, dat(1, 12), 1);
    tbl[10] = mk(0, 2'b00, 0, 0, 0, 0, 1, 3, dat(0, 3), 0);
    tbl[11] = mk(0, 2'b00, 0, 0, 0, 0, 1, 13, dat(1, 13), 1);
    tbl[12] = mk(0, 2'b00, 0, 0, 0, 0, 1, 4, dat(0, 4), 0);
    tbl[13] = mk(0, 2'b00, 0, 0, 0, 0, 1, 14, dat(1, 14), 1);
    tbl[14] = mk(0, 2'b00, 0, 0, 0, 0, 0, 14, dat(1, 14), 1);

    // Reset state
    do_reset();
    check("rst_bus", {cdb_valid_out, cdb_src_out, cdb_tag_out, cdb_data_out}, 64'd0);
    check("rst_full", src_full_out, 2'b00);
    check("rst_ovf", overflow_out, 2'b00);

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].do_rst) do_reset();
      drive(1'b1, 1'b0, tbl[i].vld, tbl[i].t0, tbl[i].t1, tbl[i].d0, tbl[i].d1, tbl[i].vld);
      check($sformatf("vec%0d", i),
            {cdb_valid_out, cdb_src_out, cdb_tag_out, cdb_data_out},
            {tbl[i].e_vld, tbl[i].e_src, tbl[i].e_tag, tbl[i].e_data});
    end
    check_drained("rr_drained");

    // Stall: rdy_in low freezes the bus and ignores pushes.
    do_reset();
    drive(1'b1, 1'b0, 2'b11, 21, 31, dat(0, 21), dat(1, 31), 2'b11);
    drive(1'b1, 1'b0, 2'b01, 22, 0, dat(0, 22), 0, 2'b01);
    check("pre_stall", {cdb_valid_out, cdb_src_out, cdb_tag_out, cdb_data_out},
          {1'b1, 1'b0, 5'd21, dat(0, 21)});
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 2'b11, 23, 29, dat(0, 23), dat(1, 29), 2'b00);
      check($sformatf("stall%0d", i), {cdb_valid_out, cdb_src_out, cdb_tag_out, cdb_data_out},
            {1'b1, 1'b0, 5'd21, dat(0, 21)});
    end
    idle();
    check("resume1", {cdb_valid_out, cdb_src_out, cdb_tag_out}, {1'b1, 1'b1, 5'd31});
    idle();
    check("resume2", {cdb_valid_out, cdb_src_out, cdb_tag_out}, {1'b1, 1'b0, 5'd22});
    idle();
    check("resume_idle", cdb_valid_out, 1'b0);
    check_drained("stall_drained");

    // Full / overflow: both channels push every cycle regardless of full.
    do_reset();
    for (int n = 0; n < 12; n++) begin
      acc[0] = (n <= 7) || (n % 2 == 1);
      acc[1] = (n <= 6) || (n % 2 == 0);
      drive(1'b1, 1'b0, 2'b11, TW'(n), TW'(16 + n), dat(0, n), dat(1, 16 + n), acc);
      check($sformatf("full%0d", n), src_full_out, (n <= 4) ? 2'b00 : (n == 5) ? 2'b10 : 2'b11);
      check($sformatf("ovf%0d", n), overflow_out, (n <= 6) ? 2'b00 : (n == 7) ? 2'b10 : 2'b11);
    end
    repeat (12) idle();
    check("ovf_full_after", src_full_out, 2'b00);
    check("ovf_sticky", overflow_out, 2'b11);
    check_drained("ovf_drained");

    // Rollback with 3 entries queued on ch0 and a same-cycle push on ch1.
    for (int n = 1; n <= 5; n++)
      drive(1'b1, 1'b0, 2'b11, TW'(n), TW'(16 + n), dat(0, n), dat(1, 16 + n), 2'b11);
    drive(1'b1, 1'b1, 2'b10, 0, 9, 0, dat(1, 9), 2'b00);
    q0.delete();
    q1.delete();
    check("rb_valid", cdb_valid_out, 1'b0);
    check("rb_full", src_full_out, 2'b00);
    check("rb_ovf", overflow_out, 2'b11);
    repeat (6) idle();
    drive(1'b1, 1'b0, 2'b11, 7, 8, dat(0, 7), dat(1, 8), 2'b11);
    check("rb_lat1", cdb_valid_out, 1'b0);
    idle();
    check("rb_first", {cdb_valid_out, cdb_src_out, cdb_tag_out}, {1'b1, 1'b1, 5'd8});
    idle();
    check("rb_second", {cdb_valid_out, cdb_src_out, cdb_tag_out}, {1'b1, 1'b0, 5'd7});
    idle();
    check("rb_idle", cdb_valid_out, 1'b0);
    check_drained("rb_drained");

    // Asynchronous reset between edges with entries in flight.
    for (int n = 1; n <= 5; n++)
      drive(1'b1, 1'b0, 2'b11, TW'(n), TW'(16 + n), dat(0, n), dat(1, 16 + n), 2'b11);
    check("ar_pre_valid", cdb_valid_out, 1'b1);
    src_valid_in = '0;
    #3;
    rst_in = 1'b0;
    #1;
    q0.delete();
    q1.delete();
    check("ar_valid", cdb_valid_out, 1'b0);
    check("ar_bus", {cdb_src_out, cdb_tag_out, cdb_data_out}, 64'd0);
    check("ar_full", src_full_out, 2'b00);
    check("ar_ovf", overflow_out, 2'b00);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    repeat (6) idle();
    check("ar_quiet", cdb_valid_out, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 0, 3, 0, dat(1, 3), 2'b10);
    check("ar_lat1", cdb_valid_out, 1'b0);
    idle();
    check("ar_first", {cdb_valid_out, cdb_src_out, cdb_tag_out, cdb_data_out},
          {1'b1, 1'b1, 5'd3, dat(1, 3)});
    idle();
    check_drained("ar_drained");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
Parametrised common-data-bus arbiter for the Tomasulo core. It replaces the point-to-point ALU/LSU result wiring with NUM_SRC buffered producer channels. Channels are drained round-robin onto one registered broadcast bus (tag = RoB id, data = result), which feeds RS, LSB and RoB. A per-channel FIFO absorbs contention, and a rollback flushes all in-flight results.

Parameters:
NUM_SRC, 2, number of producer channels (≥1)
DATA_W, 32, result width
TAG_W, 5, RoB id width
FIFO_DEPTH, 4, entries per channel FIFO (power of 2, ≥2)
localparam SRC_W = max(1, clog2(NUM_SRC)); CNT_W = clog2(FIFO_DEPTH)+1

Ports:
clk_in  input  1  system clock, all state on rising edge
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global ready; low freezes all state
rollback_in  input  1  synchronous flush from RoB
src_valid_in  input  NUM_SRC  per-channel result valid
src_tag_in  input  NUM_SRC*TAG_W  per-channel RoB id, channel i at [i*TAG_W +: TAG_W]
src_data_in  input  NUM_SRC*DATA_W  per-channel result, channel i at [i*DATA_W +: DATA_W]
src_full_out  output  NUM_SRC  channel FIFO full; producer must hold its result
overflow_out  output  NUM_SRC  sticky: push was dropped on a full FIFO
cdb_valid_out  output  1  broadcast valid (registered)
cdb_tag_out  output  TAG_W  broadcast RoB id (registered)
cdb_data_out  output  DATA_W  broadcast result (registered)
cdb_src_out  output  SRC_W  channel index of current broadcast (registered)

Behaviour:
- Reset (rst_in low, async):
  - All FIFOs emptied; counts, pointers, cdb_* and overflow_out cleared to 0.
  - Round-robin pointer last_grant = NUM_SRC-1, so channel 0 wins first.
  - Takes effect immediately, also mid-transfer.
- rdy_in low: no state change at all, outputs hold. rdy_in gates every rule below.
- Per-channel FIFO:
  - Circular buffer with wr_ptr/rd_ptr of clog2(FIFO_DEPTH) bits (natural wrap) and count of CNT_W bits.
  - src_full_out[i] = (count_i == FIFO_DEPTH), combinational from state.
- Push: src_valid_in[i] high, rollback_in low, and (count_i < FIFO_DEPTH or channel i popped this cycle) -> entry written.
  - Push on a full FIFO with no pop: entry dropped, overflow_out[i] set; it stays set until reset.
- Arbitration (combinational, each cycle):
  - Scan channels starting at last_grant+1 (mod NUM_SRC).
  - The first channel with count > 0 is granted and popped.
  - last_grant is updated to the granted channel; it is unchanged if no grant.
- Broadcast register, at the clock edge:
  - On a grant: cdb_valid_out=1; cdb_tag_out, cdb_data_out and cdb_src_out load the FIFO head.
  - No grant: cdb_valid_out=0; tag/data/src hold their last values.
  - Each entry is broadcast exactly once, for exactly one cycle.
- Latency:
  - Result presented in cycle t on an empty channel with no competition -> cdb_valid_out high in cycle t+2.
  - Sustained throughput: 1 broadcast/cycle total.
- Simultaneous push and pop on the same channel: count unchanged, both pointers advance.
- Rollback_in high (with rdy_in):
  - All FIFOs emptied and cdb_valid_out cleared at the edge.
  - Same-cycle pushes and grants are discarded.
  - last_grant and overflow_out are unchanged.
  - First post-rollback push is broadcast under the normal latency.
- NUM_SRC=1: arbiter degenerates to a FIFO + output register; cdb_src_out is always 0.

Test Plan:
1. Reset/single push: NUM_SRC=2. Release rst_in, push ch0 tag=5 data=0xDEADBEEF in cycle 3 -> cycle 5: cdb_valid_out=1, tag=5, data=0xDEADBEEF, src=0; cycle 6: valid=0, tag/data held.
2. Round-robin: both channels push every cycle for 4 cycles (ch0 tags 1-4, ch1 tags 11-14) -> broadcasts in order 1,11,2,12,3,13,4,14 on 8 consecutive cycles; src alternates 0,1; no entry lost.
3. Full/overflow: NUM_SRC=4, FIFO_DEPTH=4, all channels push every cycle ignoring full -> src_full_out rises on each channel; dropped pushes set overflow_out; every accepted tag is broadcast exactly once, in per-channel order.
4. Rollback: ch0 holds 3 entries, ch1 pushes tag 9 in the rollback cycle -> next cycle cdb_valid_out=0, src_full_out=0; no further broadcasts; overflow_out unchanged.
5. Stall: 2 entries queued, rdy_in low for 3 cycles -> cdb_* frozen, pushes ignored; resumes exactly where it paused when rdy_in returns high.
6. Async reset mid-stream: assert rst_in between clock edges with 3 entries queued -> cdb_valid_out=0 immediately, no broadcast after release until a new push.
